// File: rtl/mips_fetch_pkg.sv
// Shared constants and state encoding for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Flags whether a fetch address is word-aligned and inside instruction memory.
module fetch_addr_check
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic        legal
);

    assign legal = (pc[1:0] == 2'b00) && (pc >= IM_LO) && (pc <= IM_HI);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC sequencing with exception/ERET/stall/branch redirect and the IF/ID register.
// state | meaning
// RUN   | normal fetch, IF/ID loads each unstalled cycle
// FLUSH | cycle after exc_req or eret; IF/ID holds a bubble (d_valid 0)
module fetch_ctrl
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        d_is_branch,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exccode,
    output logic        d_bd,
    output logic        d_valid
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  d_pc_next, d_instr_next;
    logic [4:0]   d_exccode_next;
    logic         d_bd_next, d_valid_next;
    logic         legal;

    fetch_addr_check u_addr_check (
        .pc    (pc),
        .legal (legal)
    );

    assign im_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= PC_RESET;
            d_pc      <= '0;
            d_instr   <= '0;
            d_exccode <= '0;
            d_bd      <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            d_pc      <= d_pc_next;
            d_instr   <= d_instr_next;
            d_exccode <= d_exccode_next;
            d_bd      <= d_bd_next;
            d_valid   <= d_valid_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = (exc_req || eret) ? FLUSH : RUN;
            FLUSH:   state_next = (exc_req || eret) ? FLUSH : RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_next        = pc;
        d_pc_next      = d_pc;
        d_instr_next   = d_instr;
        d_exccode_next = d_exccode;
        d_bd_next      = d_bd;
        d_valid_next   = d_valid;

        if (exc_req || eret) begin
            // The faulting/returning fetch is discarded, but its pc is kept for debug visibility.
            pc_next        = exc_req ? EXC_ENTRY : epc;
            d_pc_next      = pc;
            d_instr_next   = '0;
            d_exccode_next = '0;
            d_bd_next      = 1'b0;
            d_valid_next   = 1'b0;
        end else if (!stall) begin
            pc_next        = br_taken ? br_target : pc + 32'd4;
            d_pc_next      = pc;
            d_bd_next      = d_is_branch;
            d_valid_next   = 1'b1;
            d_instr_next   = legal ? im_data : 32'h0;
            d_exccode_next = legal ? 5'd0 : EXC_ADEL;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction-memory stand-in.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, d_is_branch, exc_req, eret;
    logic [31:0] br_target, epc, im_addr, im_data, d_pc, d_instr;
    logic [4:0]  d_exccode;
    logic        d_bd, d_valid;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .d_is_branch (d_is_branch),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .d_pc        (d_pc),
        .d_instr     (d_instr),
        .d_exccode   (d_exccode),
        .d_bd        (d_bd),
        .d_valid     (d_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign im_data = mem_word(im_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; br_taken = 0; br_target = '0;
        d_is_branch = 0; exc_req = 0; eret = 0; epc = '0;
    endtask

    task automatic jump(input logic [31:0] t);
        br_taken = 1; br_target = t;
        step();
        br_taken = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        step(); step();
        chk("rst_im_addr", im_addr, 32'h3000);
        chk("rst_d_pc", d_pc, 32'h0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'h0);
        chk("rst_d_instr", d_instr, 32'h0);
        chk("rst_d_exccode", {27'b0, d_exccode}, 32'h0);
        chk("rst_d_bd", {31'b0, d_bd}, 32'h0);

        reset = 0;
        step();
        chk("run1_im_addr", im_addr, 32'h3004);
        chk("run1_d_pc", d_pc, 32'h3000);
        chk("run1_d_valid", {31'b0, d_valid}, 32'h1);
        chk("run1_d_instr", d_instr, 32'hA5A5_3000);
        step();
        chk("run2_im_addr", im_addr, 32'h3008);
        chk("run2_d_pc", d_pc, 32'h3004);
        step(); step();
        chk("pre_br_im_addr", im_addr, 32'h3010);

        d_is_branch = 1;
        jump(32'h3100);
        d_is_branch = 0;
        chk("br_d_pc", d_pc, 32'h3010);
        chk("br_d_bd", {31'b0, d_bd}, 32'h1);
        chk("br_im_addr", im_addr, 32'h3100);
        step();
        chk("slot_d_pc", d_pc, 32'h3100);
        chk("slot_d_bd", {31'b0, d_bd}, 32'h0);
        chk("slot_im_addr", im_addr, 32'h3104);

        jump(32'h3020);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_im_addr", im_addr, 32'h3020);
            chk("stall_d_pc", d_pc, 32'h3104);
            chk("stall_d_instr", d_instr, 32'hA5A5_3104);
            chk("stall_d_valid", {31'b0, d_valid}, 32'h1);
        end
        stall = 0;
        step();
        chk("unstall_im_addr", im_addr, 32'h3024);
        chk("unstall_d_pc", d_pc, 32'h3020);

        stall = 1; br_taken = 1; br_target = 32'h5000;
        step();
        chk("brstall_im_addr", im_addr, 32'h3024);
        chk("brstall_d_pc", d_pc, 32'h3020);
        stall = 0; br_taken = 0;

        jump(32'h3040);
        exc_req = 1; stall = 1;
        step();
        chk("exc_im_addr", im_addr, 32'h4180);
        chk("exc_d_valid", {31'b0, d_valid}, 32'h0);
        chk("exc_d_pc", d_pc, 32'h3040);
        chk("exc_d_instr", d_instr, 32'h0);
        exc_req = 0; stall = 0;
        step();
        chk("post_exc_d_pc", d_pc, 32'h4180);
        chk("post_exc_d_valid", {31'b0, d_valid}, 32'h1);
        chk("post_exc_d_instr", d_instr, 32'hA5A5_4180);
        chk("post_exc_im_addr", im_addr, 32'h4184);

        eret = 1; epc = 32'h3002;
        step();
        chk("eret_im_addr", im_addr, 32'h3002);
        chk("eret_d_valid", {31'b0, d_valid}, 32'h0);
        chk("eret_d_pc", d_pc, 32'h4184);
        eret = 0;
        step();
        chk("mis_d_exccode", {27'b0, d_exccode}, 32'h4);
        chk("mis_d_instr", d_instr, 32'h0);
        chk("mis_d_pc", d_pc, 32'h3002);
        chk("mis_d_valid", {31'b0, d_valid}, 32'h1);
        chk("mis_im_addr", im_addr, 32'h3006);

        jump(32'h6FFC);
        step();
        chk("hi_d_pc", d_pc, 32'h6FFC);
        chk("hi_d_exccode", {27'b0, d_exccode}, 32'h0);
        chk("hi_d_instr", d_instr, 32'hA5A5_6FFC);
        chk("hi_im_addr", im_addr, 32'h7000);
        step();
        chk("past_hi_d_pc", d_pc, 32'h7000);
        chk("past_hi_d_exccode", {27'b0, d_exccode}, 32'h4);
        chk("past_hi_d_instr", d_instr, 32'h0);
        chk("past_hi_im_addr", im_addr, 32'h7004);

        jump(32'hFFFF_FFFC);
        step();
        chk("wrap_im_addr", im_addr, 32'h0);
        chk("wrap_d_exccode", {27'b0, d_exccode}, 32'h4);

        jump(32'h2FFC);
        step();
        chk("lo_d_pc", d_pc, 32'h2FFC);
        chk("lo_d_exccode", {27'b0, d_exccode}, 32'h4);
        step();
        chk("lo_ok_d_pc", d_pc, 32'h3000);
        chk("lo_ok_d_exccode", {27'b0, d_exccode}, 32'h0);

        exc_req = 1;
        step(); step();
        chk("exc2_im_addr", im_addr, 32'h4180);
        chk("exc2_d_pc", d_pc, 32'h4180);
        chk("exc2_d_valid", {31'b0, d_valid}, 32'h0);

        reset = 1; stall = 1;
        step();
        chk("rst_ovr_im_addr", im_addr, 32'h3000);
        chk("rst_ovr_d_pc", d_pc, 32'h0);
        chk("rst_ovr_d_valid", {31'b0, d_valid}, 32'h0);
        idle();
        step();
        chk("rst_rel_d_pc", d_pc, 32'h3000);
        chk("rst_rel_d_valid", {31'b0, d_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
